// File: rtl/fetch_redirect_ctrl.sv
// Fetch redirect controller: arbitrates trap, mispredict, fence/CSR and
// predictor redirects onto the PC alter/target/stall inputs, buffers one
// redirect while fetch is busy, runs a squash window after backend
// redirects and parks fetch on WFI.
module fetch_redirect_ctrl #(
  parameter int unsigned          PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0]  RESET_VECTOR = PC_WIDTH'(32'h8000_0000),
  parameter int unsigned          FLUSH_CYCLES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_exc_valid,
  input  logic [PC_WIDTH-1:0] i_exc_pc,
  input  logic                i_mispred_valid,
  input  logic [PC_WIDTH-1:0] i_mispred_pc,
  input  logic                i_fence_valid,
  input  logic [PC_WIDTH-1:0] i_fence_pc,
  input  logic                i_bp_valid,
  input  logic [PC_WIDTH-1:0] i_bp_pc,
  input  logic                i_fetch_busy,
  input  logic                i_backend_stall,
  input  logic                i_wfi,
  input  logic                i_wake,
  output logic                o_alter,
  output logic [PC_WIDTH-1:0] o_pc,
  output logic                o_stall,
  output logic                o_flush,
  output logic [1:0]          o_state
);

  typedef enum logic [1:0] {
    StBoot  = 2'd0,
    StRun   = 2'd1,
    StDrain = 2'd2,
    StHalt  = 2'd3
  } state_e;

  localparam logic [3:0] FlushLoad = 4'(FLUSH_CYCLES);

  state_e              state_q;
  logic                pend_valid_q;
  logic [1:0]          pend_prio_q;
  logic [PC_WIDTH-1:0] pend_pc_q;
  logic [3:0]          cnt_q;

  logic                new_valid;
  logic [1:0]          new_prio;
  logic [PC_WIDTH-1:0] new_pc;
  logic                win_valid;
  logic [1:0]          win_prio;
  logic [PC_WIDTH-1:0] win_pc;

  // Highest-priority request this cycle; predictor requests only count in RUN.
  always_comb begin
    new_valid = 1'b1;
    new_prio  = 2'd0;
    new_pc    = '0;
    if (i_exc_valid) begin
      new_prio = 2'd3;
      new_pc   = i_exc_pc;
    end else if (i_mispred_valid) begin
      new_prio = 2'd2;
      new_pc   = i_mispred_pc;
    end else if (i_fence_valid) begin
      new_prio = 2'd1;
      new_pc   = i_fence_pc;
    end else if (i_bp_valid && (state_q == StRun)) begin
      new_prio = 2'd0;
      new_pc   = i_bp_pc;
    end else begin
      new_valid = 1'b0;
    end
  end

  // Merge with the pending entry: the newer request wins at equal or higher priority.
  // A predictor request loses to any pending backend entry by priority alone.
  always_comb begin
    win_valid = new_valid || pend_valid_q;
    win_prio  = pend_prio_q;
    win_pc    = pend_pc_q;
    if (new_valid && (!pend_valid_q || (new_prio >= pend_prio_q))) begin
      win_prio = new_prio;
      win_pc   = new_pc;
    end
  end

  // Control FSM with registered alter/pc/stall/flush outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StBoot;
      pend_valid_q <= 1'b0;
      pend_prio_q  <= 2'd0;
      pend_pc_q    <= '0;
      cnt_q        <= 4'd0;
      o_alter      <= 1'b0;
      o_pc         <= RESET_VECTOR;
      o_stall      <= 1'b1;
      o_flush      <= 1'b1;
    end else begin
      o_alter <= 1'b0;
      unique case (state_q)
        StBoot: begin
          // Requests seen here are dropped; the first fetch always goes to the reset vector.
          o_alter <= 1'b1;
          o_pc    <= RESET_VECTOR;
          o_flush <= 1'b0;
          o_stall <= 1'b1;
          state_q <= StRun;
        end

        StRun: begin
          o_flush <= 1'b0;
          if (win_valid && !i_fetch_busy) begin
            o_alter      <= 1'b1;
            o_pc         <= win_pc;
            pend_valid_q <= 1'b0;
            if (win_prio != 2'd0) begin
              o_flush <= 1'b1;
              o_stall <= 1'b1;
              cnt_q   <= FlushLoad;
              state_q <= StDrain;
            end else begin
              // Stall stays up through the issue cycle of a buffered entry.
              o_stall <= pend_valid_q || i_backend_stall;
            end
          end else if (win_valid) begin
            pend_valid_q <= 1'b1;
            pend_prio_q  <= win_prio;
            pend_pc_q    <= win_pc;
            o_stall      <= 1'b1;
          end else if (i_wfi) begin
            o_stall <= 1'b1;
            state_q <= StHalt;
          end else begin
            o_stall <= i_backend_stall;
          end
        end

        StDrain: begin
          o_flush <= 1'b1;
          o_stall <= 1'b1;
          if (win_valid && (win_prio != 2'd0) && !i_fetch_busy) begin
            // Back-to-back backend redirect restarts the squash window.
            o_alter      <= 1'b1;
            o_pc         <= win_pc;
            pend_valid_q <= 1'b0;
            cnt_q        <= FlushLoad;
          end else begin
            if (win_valid && (win_prio != 2'd0)) begin
              pend_valid_q <= 1'b1;
              pend_prio_q  <= win_prio;
              pend_pc_q    <= win_pc;
            end
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
              state_q <= StRun;
            end
          end
        end

        StHalt: begin
          o_flush <= 1'b0;
          o_stall <= 1'b1;
          if (i_exc_valid) begin
            if (!i_fetch_busy) begin
              o_alter <= 1'b1;
              o_pc    <= i_exc_pc;
              o_flush <= 1'b1;
              cnt_q   <= FlushLoad;
              state_q <= StDrain;
            end else begin
              // Fetch still busy: hold the trap and let RUN issue it.
              pend_valid_q <= 1'b1;
              pend_prio_q  <= 2'd3;
              pend_pc_q    <= i_exc_pc;
              state_q      <= StRun;
            end
          end else if (i_wake) begin
            state_q <= StRun;
          end
        end

        default: state_q <= StBoot;
      endcase
    end
  end

  assign o_state = state_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Self-checking bench for fetch_redirect_ctrl: each step pushes the expected
// outputs to a scoreboard queue, which is popped and compared after the edge.
module tb_fetch_redirect_ctrl;

  localparam logic [1:0] BOOT = 2'd0, RUN = 2'd1, DRAIN = 2'd2, HALT = 2'd3;
  localparam logic [31:0] RV = 32'h8000_0000;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_exc_valid, i_mispred_valid, i_fence_valid, i_bp_valid;
  logic [31:0] i_exc_pc, i_mispred_pc, i_fence_pc, i_bp_pc;
  logic        i_fetch_busy, i_backend_stall, i_wfi, i_wake;
  logic        o_alter, o_stall, o_flush;
  logic [31:0] o_pc;
  logic [1:0]  o_state;

  typedef struct {
    logic        alter;
    logic [31:0] pc;
    logic        chk_pc;
    logic        stall;
    logic        flush;
    logic [1:0]  state;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  fetch_redirect_ctrl #(
    .PC_WIDTH    (32),
    .RESET_VECTOR(RV),
    .FLUSH_CYCLES(2)
  ) dut (
    .i_clk          (i_clk),
    .i_rst          (i_rst),
    .i_exc_valid    (i_exc_valid),
    .i_exc_pc       (i_exc_pc),
    .i_mispred_valid(i_mispred_valid),
    .i_mispred_pc   (i_mispred_pc),
    .i_fence_valid  (i_fence_valid),
    .i_fence_pc     (i_fence_pc),
    .i_bp_valid     (i_bp_valid),
    .i_bp_pc        (i_bp_pc),
    .i_fetch_busy   (i_fetch_busy),
    .i_backend_stall(i_backend_stall),
    .i_wfi          (i_wfi),
    .i_wake         (i_wake),
    .o_alter        (o_alter),
    .o_pc           (o_pc),
    .o_stall        (o_stall),
    .o_flush        (o_flush),
    .o_state        (o_state)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  // Drive happens before the call; expectation covers outputs after the next edge.
  task automatic tick(input string tag, input logic a, input logic [31:0] pc, input logic cpc,
                      input logic st, input logic fl, input logic [1:0] s);
    exp_t e;
    e.alter  = a;
    e.pc     = pc;
    e.chk_pc = cpc;
    e.stall  = st;
    e.flush  = fl;
    e.state  = s;
    exp_q.push_back(e);
    @(posedge i_clk);
    #1;
    if (exp_q.size() == 0) begin
      check_eq({tag, ".queue"}, 32'd0, 32'd1);
    end else begin
      e = exp_q.pop_front();
      check_eq({tag, ".alter"}, 32'(o_alter), 32'(e.alter));
      check_eq({tag, ".stall"}, 32'(o_stall), 32'(e.stall));
      check_eq({tag, ".flush"}, 32'(o_flush), 32'(e.flush));
      check_eq({tag, ".state"}, 32'(o_state), 32'(e.state));
      if (e.chk_pc) check_eq({tag, ".pc"}, o_pc, e.pc);
    end
    i_exc_valid     = 1'b0;
    i_mispred_valid = 1'b0;
    i_fence_valid   = 1'b0;
    i_bp_valid      = 1'b0;
    i_wfi           = 1'b0;
    i_wake          = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1;
    i_exc_valid = 0; i_mispred_valid = 0; i_fence_valid = 0; i_bp_valid = 0;
    i_exc_pc = 0; i_mispred_pc = 0; i_fence_pc = 0; i_bp_pc = 0;
    i_fetch_busy = 0; i_backend_stall = 0; i_wfi = 0; i_wake = 0;

    // Reset and boot; a request during BOOT is ignored.
    tick("reset", 0, RV, 1, 1, 1, BOOT);
    i_rst = 1'b0;
    i_mispred_valid = 1; i_mispred_pc = 32'hdead;
    tick("boot", 1, RV, 1, 1, 0, RUN);
    tick("run0", 0, RV, 1, 0, 0, RUN);

    // Mispredict beats predictor; 3 flush cycles.
    i_mispred_valid = 1; i_mispred_pc = 32'h100;
    i_bp_valid = 1; i_bp_pc = 32'h200;
    tick("misp", 1, 32'h100, 1, 1, 1, DRAIN);
    tick("misp_d1", 0, 0, 0, 1, 1, DRAIN);
    tick("misp_d2", 0, 0, 0, 1, 1, RUN);
    tick("misp_end", 0, 32'h100, 1, 0, 0, RUN);

    // Busy fetch: fence pended, replaced by later trap, single issue.
    i_fetch_busy = 1;
    i_fence_valid = 1; i_fence_pc = 32'h300;
    tick("busy1", 0, 0, 0, 1, 0, RUN);
    i_exc_valid = 1; i_exc_pc = 32'h400;
    tick("busy2", 0, 0, 0, 1, 0, RUN);
    tick("busy3", 0, 32'h100, 1, 1, 0, RUN);
    i_fetch_busy = 0;
    tick("pend_issue", 1, 32'h400, 1, 1, 1, DRAIN);
    i_bp_valid = 1; i_bp_pc = 32'h444;
    tick("drain_bp", 0, 32'h400, 1, 1, 1, DRAIN);

    // Trap in DRAIN with counter at 1 reloads the window.
    i_exc_valid = 1; i_exc_pc = 32'h500;
    tick("reload", 1, 32'h500, 1, 1, 1, DRAIN);
    tick("reload_d1", 0, 0, 0, 1, 1, DRAIN);
    tick("reload_d2", 0, 0, 0, 1, 1, RUN);
    tick("reload_end", 0, 0, 0, 0, 0, RUN);

    // Predictor-only redirect and backend back-pressure.
    i_bp_valid = 1; i_bp_pc = 32'h700;
    tick("bp", 1, 32'h700, 1, 0, 0, RUN);
    i_backend_stall = 1;
    tick("bstall", 0, 0, 0, 1, 0, RUN);
    i_backend_stall = 0;
    tick("bstall_off", 0, 0, 0, 0, 0, RUN);

    // Equal priority: newer buffered predictor request wins.
    i_fetch_busy = 1;
    i_bp_valid = 1; i_bp_pc = 32'hA00;
    tick("bp_pend1", 0, 0, 0, 1, 0, RUN);
    i_bp_valid = 1; i_bp_pc = 32'hB00;
    tick("bp_pend2", 0, 0, 0, 1, 0, RUN);
    i_fetch_busy = 0;
    tick("bp_issue", 1, 32'hB00, 1, 1, 0, RUN);
    tick("bp_idle", 0, 32'hB00, 1, 0, 0, RUN);

    // WFI then wake; requests other than trap ignored in HALT.
    i_wfi = 1;
    tick("wfi", 0, 0, 0, 1, 0, HALT);
    i_fence_valid = 1; i_fence_pc = 32'h333;
    i_bp_valid = 1; i_bp_pc = 32'h222;
    tick("halt_ign", 0, 32'hB00, 1, 1, 0, HALT);
    i_wake = 1;
    tick("wake", 0, 0, 0, 1, 0, RUN);
    tick("wake_idle", 0, 32'hB00, 1, 0, 0, RUN);

    // WFI then trap leaves HALT through DRAIN.
    i_wfi = 1;
    tick("wfi2", 0, 0, 0, 1, 0, HALT);
    i_exc_valid = 1; i_exc_pc = 32'h600;
    tick("halt_exc", 1, 32'h600, 1, 1, 1, DRAIN);
    tick("halt_d1", 0, 0, 0, 1, 1, DRAIN);
    tick("halt_d2", 0, 0, 0, 1, 1, RUN);
    tick("halt_end", 0, 0, 0, 0, 0, RUN);

    // Reset mid-DRAIN with a pending entry discards it.
    i_mispred_valid = 1; i_mispred_pc = 32'h800;
    tick("rd_misp", 1, 32'h800, 1, 1, 1, DRAIN);
    i_fetch_busy = 1;
    i_fence_valid = 1; i_fence_pc = 32'h900;
    tick("rd_pend", 0, 0, 0, 1, 1, DRAIN);
    i_rst = 1;
    tick("rd_reset", 0, RV, 1, 1, 1, BOOT);
    i_rst = 0;
    i_fetch_busy = 0;
    tick("rd_boot", 1, RV, 1, 1, 0, RUN);
    for (int i = 0; i < 3; i++) begin
      tick($sformatf("rd_idle%0d", i), 0, RV, 1, 0, 0, RUN);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_redirect_ctrl.md
Name: fetch_redirect_ctrl

Overview:
- Sequences the fetch program counter.
- Arbitrates redirect requests from four sources: trap/exception, branch mispredict, fence/CSR flush, and branch predictor. It drives the PC's alter/target/stall inputs.
- Holds a redirect in a pending buffer while the fetch unit is mid-transaction.
- Runs a frontend-squash window after backend redirects and parks fetch on WFI.

Parameters:
- PC_WIDTH, 32, width of all PC values
- RESET_VECTOR, 32'h8000_0000, target issued on the first redirect after reset
- FLUSH_CYCLES, 2, squash/stall cycles after a backend redirect, range 1..15

Ports:
- i_clk  in  1  clock
- i_rst  in  1  reset; one clock, reset is synchronous and active-high
- i_exc_valid / i_exc_pc  in  1 / PC_WIDTH  trap redirect, priority 3 (highest)
- i_mispred_valid / i_mispred_pc  in  1 / PC_WIDTH  branch resolve redirect, priority 2
- i_fence_valid / i_fence_pc  in  1 / PC_WIDTH  fence.i/CSR refetch, priority 1
- i_bp_valid / i_bp_pc  in  1 / PC_WIDTH  predictor redirect, priority 0
- i_fetch_busy  in  1  fetch transaction in flight; PC must not be altered
- i_backend_stall  in  1  decode back-pressure
- i_wfi  in  1  enter halt request
- i_wake  in  1  interrupt pending, leave halt
- o_alter  out  1  to PC alter input
- o_pc  out  PC_WIDTH  to PC target input
- o_stall  out  1  to PC stall input
- o_flush  out  1  squash frontend pipeline
- o_state  out  2  BOOT=0, RUN=1, DRAIN=2, HALT=3

Behaviour:
- All outputs are registered. A request sampled at edge N appears on o_alter during cycle N+1, so the PC takes the target at edge N+2.
- Reset, when i_rst is high at an edge:
  - state=BOOT, pending cleared, counter=0.
  - o_alter=0, o_pc=RESET_VECTOR, o_stall=1, o_flush=1.
  - Reset mid-DRAIN or mid-pending discards everything.
- BOOT:
  - First non-reset edge: o_alter=1, o_pc=RESET_VECTOR, o_flush=0, state=RUN.
  - Any request arriving in BOOT is ignored.
- Arbitration:
  - Winner = highest-priority valid input this cycle, merged with the pending entry.
  - A new input replaces the pending entry if its priority is greater than or equal to the pending priority. At equal priority the newer request wins.
  - A bp request is dropped whenever any backend request (priority >= 1) is valid or pending.
- RUN, winner exists, i_fetch_busy=0:
  - Next cycle: o_alter=1, o_pc=winner pc, pending cleared.
  - If winner priority >= 1: o_flush=1, counter=FLUSH_CYCLES, state=DRAIN.
  - bp winner: no flush, stay RUN.
- RUN, winner exists, i_fetch_busy=1:
  - Winner is latched into pending.
  - o_alter=0, o_stall=1 until it issues, on the first cycle with fetch not busy.
- RUN, no winner, i_wfi=1, no pending: state=HALT next cycle.
- DRAIN:
  - o_stall=1 and o_flush=1; counter decrements each cycle; state=RUN on the edge where counter goes 1->0.
  - A new backend request, if fetch is not busy: issue immediately, reload counter to FLUSH_CYCLES. If fetch is busy: pend it.
  - bp requests are ignored.
- HALT:
  - o_stall=1, o_flush=0.
  - i_exc_valid: issue exc redirect, go to DRAIN.
  - Else i_wake: state=RUN, no alter.
  - Other requests are ignored.
- o_stall (registered):
  - Equals 1 when state≠RUN, a pending entry exists, or i_backend_stall=1.
  - o_alter has precedence over o_stall at the PC.
- o_alter is a single-cycle pulse per accepted redirect and is never high in consecutive cycles for the same pending entry.

Test Plan:
- Reset then release: cycle 1 shows o_alter=1, o_pc=32'h8000_0000, o_state goes BOOT->RUN, and o_stall drops the next cycle.
- i_mispred_valid (pc 0x100) and i_bp_valid (pc 0x200) at the same edge: o_alter with o_pc=0x100, o_flush high for 1 + FLUSH_CYCLES (=3) cycles, state DRAIN->RUN, bp dropped.
- i_fetch_busy=1 for 3 cycles with i_fence (0x300), then i_exc (0x400) arriving a cycle later: exactly one o_alter pulse, to 0x400, in the cycle after busy falls; o_stall stays high throughout.
- In DRAIN with counter=1, an i_exc redirect to 0x500 arrives: o_alter to 0x500, counter reloads, and DRAIN lasts a further FLUSH_CYCLES cycles.
- i_wfi in RUN: state HALT and o_stall=1. Then i_wake: state RUN, o_alter=0. Repeat with i_exc in HALT: redirect is issued and state goes to DRAIN.
- Assert i_rst mid-DRAIN with an entry pending: next cycle is BOOT with reset outputs, and the pending redirect is never issued.
